ghost_cmd_router: RTL and testbench
===================================

GHOST_CMD_ROUTER -- requirements
Module: ghost_cmd_router

Interface
REQ-001 Parameter N_CH, default 2: number of output channels, range 1..16.
REQ-002 Parameter DATA_W, default 8: channel payload width, a multiple of 8 in the range 8..32; NB = DATA_W/8 payload bytes per frame.
REQ-003 Parameter INVERT, default 1: when 1, the stored payload is the bitwise inverse of the received payload (active-low display/buzzer sinks).
REQ-004 Parameter RST_VAL, default 0: DATA_W-bit reset value of every channel register.
REQ-005 Parameter TIMEOUT_CYC, default 50000: maximum idle clocks allowed between bytes of one frame.
REQ-006 i_clk  in  1  single system clock; all logic on the rising edge.
REQ-007 i_rst  in  1  reset, asynchronous, active-high.
REQ-008 i_rx_valid  in  1  one-cycle strobe from the UART receiver marking i_rx_byte as valid.
REQ-009 i_rx_byte  in  8  received byte; sampled only when i_rx_valid=1.
REQ-010 i_ch_en  in  N_CH  per-channel write enable (generalises the 2-bit mode select).
REQ-011 o_ch_data  out  N_CH*DATA_W  channel registers; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-012 o_ch_update  out  N_CH  one-cycle pulse on the bit of each channel written.
REQ-013 o_frame_err  out  1  one-cycle pulse on a rejected frame.
REQ-014 o_err_cnt  out  8  saturating count of rejected frames.
REQ-015 o_busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 Frame format: SYNC (0xA5), ADDR, NB payload bytes MSB first, then CSUM, where CSUM = XOR of ADDR and all payload bytes.
REQ-017 FSM states and transitions:
- IDLE: on SYNC -> ADDR.
- ADDR: on any byte -> DATA; the byte is latched as the channel address.
- DATA: after NB bytes -> CSUM; a byte counter tracks the count.
- CSUM: on any byte -> IDLE.
REQ-018 State advances only on i_rx_valid=1; in IDLE, non-SYNC bytes are ignored with no error.
REQ-019 In ADDR, DATA and CSUM, 0xA5 is ordinary data; there is no mid-frame resync.
REQ-020 Commit condition: CSUM byte matches the running XOR, and ADDR < N_CH.
- Channel ADDR's register loads the payload (inverted if INVERT=1).
- o_ch_update[ADDR] pulses.
- Register and pulse take effect on the clock edge following the CSUM strobe (one-cycle latency).
REQ-021 Commit with i_ch_en[ADDR]=0: the frame is dropped silently; no register change, no update pulse, no error.
REQ-022 Checksum mismatch, or ADDR >= N_CH: o_frame_err pulses one cycle after the CSUM strobe, o_err_cnt increments, FSM -> IDLE.
REQ-023 Timeout: an inter-byte counter clears on every i_rx_valid and counts while not in IDLE.
- When it reaches TIMEOUT_CYC: error as in REQ-022, FSM -> IDLE.
- If i_rx_valid coincides with the timeout cycle, the byte wins and no timeout occurs.
REQ-024 o_err_cnt saturates at 255 and never wraps.
REQ-025 At most one o_ch_update bit is high in any cycle; o_ch_update and o_frame_err are never high together.
REQ-026 Channel registers hold their value indefinitely between commits.

Reset
REQ-027 Asserting i_rst, at any time including mid-frame, forces:
- FSM to IDLE; byte counter, XOR accumulator and timeout counter to 0;
- every channel register to RST_VAL;
- o_ch_update, o_frame_err and o_busy to 0; o_err_cnt to 0.
REQ-028 A partial frame interrupted by reset is discarded and not counted as an error.
REQ-029 The first byte accepted after reset deassertion is processed from IDLE.

Structure
REQ-030 Shared package ghost_pkg holds the SYNC constant 0xA5, the FSM state encoding and the error-counter width.
REQ-031 One sub-module, ghost_frame_timer, implements the TIMEOUT_CYC inter-byte counter with clear/enable inputs and a timeout pulse output.
REQ-032 Only one UART byte stream is consumed; the downstream seven-segment and clicker blocks connect to o_ch_data slices.

Verification (N_CH=2, DATA_W=8, INVERT=1, TIMEOUT_CYC=100 unless stated)
REQ-033 Bytes A5 01 3C 3D with i_ch_en=11 -> ch1 data = 0xC3, o_ch_update=10 for one cycle, ch0 unchanged at 0x00.
REQ-034 Bytes A5 00 3C 00 (bad CSUM) -> o_frame_err pulses, o_err_cnt=1, no channel change; A5 05 11 14 (bad ADDR) -> o_err_cnt=2.
REQ-035 Bytes A5 01, then a 100-cycle gap -> o_frame_err at cycle 100, FSM IDLE; a byte arriving exactly at cycle 100 is accepted instead.
REQ-036 Bytes A5 00 A5 A5 with i_ch_en=10 -> no update, no error; with i_ch_en=01 -> ch0 = 0x5A.
REQ-037 i_rst asserted after A5 01 3C -> all outputs at reset values; the following A5 00 0F 0F commits ch0 = 0xF0.
REQ-038 DATA_W=16: bytes A5 01 12 34 27 -> ch1 = 0xEDCB; 300 bad frames -> o_err_cnt = 255.

Source files
------------

// File: rtl/ghost_pkg.sv
// Shared constants and FSM encoding for the ghost command router.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ghost_pkg;

    // Frame start marker; only meaningful while the router is idle.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Width of the saturating rejected-frame counter.
    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

endpackage

// File: rtl/ghost_frame_timer.sv
// Inter-byte idle timer: pulses o_timeout after TIMEOUT_CYC byte-free cycles inside a frame.
// Latency: combinational pulse on the expiring cycle; counter updates on i_clk.
// Backpressure: none; a byte (i_clr) in the expiring cycle suppresses the pulse.
module ghost_frame_timer #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;

    // Count idle cycles while a frame is open; any byte or leaving the frame restarts it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_clr || !i_en) begin
            cnt_q <= '0;
        end else if (cnt_q != LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_timeout = i_en && !i_clr && (cnt_q == LAST);

endmodule

// File: rtl/ghost_cmd_router.sv
// Parses SYNC/ADDR/payload/CSUM byte frames and loads the addressed channel register.
// Latency: register load, update pulse and error pulse one cycle after the CSUM byte.
// Backpressure: none; every valid byte is consumed, bad or stale frames are dropped.
module ghost_cmd_router
    import ghost_pkg::*;
#(
    parameter int                N_CH        = 2,
    parameter int                DATA_W      = 8,
    parameter int                INVERT      = 1,
    parameter logic [DATA_W-1:0] RST_VAL     = '0,
    parameter int                TIMEOUT_CYC = 50000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rx_valid,
    input  logic [7:0]             i_rx_byte,
    input  logic [N_CH-1:0]        i_ch_en,
    output logic [N_CH*DATA_W-1:0] o_ch_data,
    output logic [N_CH-1:0]        o_ch_update,
    output logic                   o_frame_err,
    output logic [ERR_CNT_W-1:0]   o_err_cnt,
    output logic                   o_busy
);

    localparam int NB = DATA_W / 8;

    state_t                 state_q, state_d;
    logic [7:0]             addr_q;
    logic [1:0]             bcnt_q;
    logic [7:0]             xor_q;
    logic [DATA_W-1:0]      pay_q;
    logic [N_CH*DATA_W-1:0] ch_data_q;
    logic [N_CH-1:0]        ch_update_q;
    logic                   frame_err_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;

    logic              tmo;
    logic              commit;
    logic              reject;
    logic              addr_ok;
    logic              en_sel;
    logic              last_byte;
    logic [DATA_W-1:0] wr_val;

    assign addr_ok   = (addr_q < 8'(N_CH));
    assign last_byte = (bcnt_q == 2'(NB - 1));
    assign wr_val    = (INVERT != 0) ? ~pay_q : pay_q;

    ghost_frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (i_rx_valid),
        .i_en      (state_q != ST_IDLE),
        .o_timeout (tmo)
    );

    // Pick the write enable of the addressed channel (out-of-range addresses read as 0).
    always_comb begin
        en_sel = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (addr_q == 8'(k)) begin
                en_sel = i_ch_en[k];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus commit/reject decision; a byte always beats the timeout.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        reject  = 1'b0;
        if (i_rx_valid) begin
            case (state_q)
                ST_IDLE: if (i_rx_byte == SYNC_BYTE) state_d = ST_ADDR;
                ST_ADDR: state_d = ST_DATA;
                ST_DATA: if (last_byte) state_d = ST_CSUM;
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    if ((i_rx_byte == xor_q) && addr_ok) begin
                        commit = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo) begin
            state_d = ST_IDLE;
            reject  = 1'b1;
        end
    end

    // Frame datapath: address latch, running XOR, payload shift, channel writes and error count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q      <= '0;
            bcnt_q      <= '0;
            xor_q       <= '0;
            pay_q       <= '0;
            ch_data_q   <= {N_CH{RST_VAL}};
            ch_update_q <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            ch_update_q <= '0;
            frame_err_q <= reject;
            if (reject && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
            if (i_rx_valid) begin
                case (state_q)
                    ST_ADDR: begin
                        addr_q <= i_rx_byte;
                        xor_q  <= i_rx_byte;
                        bcnt_q <= '0;
                    end
                    ST_DATA: begin
                        xor_q  <= xor_q ^ i_rx_byte;
                        pay_q  <= DATA_W'({pay_q, i_rx_byte});
                        bcnt_q <= last_byte ? 2'd0 : bcnt_q + 1'b1;
                    end
                    default: ;
                endcase
            end
            for (int k = 0; k < N_CH; k++) begin
                if (commit && en_sel && (addr_q == 8'(k))) begin
                    ch_data_q[k*DATA_W +: DATA_W] <= wr_val;
                    ch_update_q[k]                <= 1'b1;
                end
            end
        end
    end

    assign o_ch_data   = ch_data_q;
    assign o_ch_update = ch_update_q;
    assign o_frame_err = frame_err_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ghost_cmd_router.sv
// Scoreboard bench for ghost_cmd_router: 8-bit and 16-bit payload instances.
// Latency: expects update/error pulses one cycle after the CSUM byte.
// Backpressure: n/a; bytes are driven as single-cycle strobes.
module tb_ghost_cmd_router;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;

    logic        rv8, rv16;
    logic [7:0]  rb8, rb16;
    logic [1:0]  en8, en16;
    logic [15:0] d8;
    logic [31:0] d16;
    logic [1:0]  up8, up16;
    logic        fe8, fe16, bz8, bz16;
    logic [7:0]  ec8, ec16;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit          is_err;
        logic [1:0]  mask;
        logic [31:0] data;
        logic [7:0]  ecnt;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];

    always #5 i_clk = ~i_clk;

    ghost_cmd_router #(
        .N_CH(2), .DATA_W(8), .INVERT(1), .RST_VAL(8'h00), .TIMEOUT_CYC(100)
    ) dut8 (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx_valid(rv8), .i_rx_byte(rb8), .i_ch_en(en8),
        .o_ch_data(d8), .o_ch_update(up8), .o_frame_err(fe8), .o_err_cnt(ec8), .o_busy(bz8)
    );

    ghost_cmd_router #(
        .N_CH(2), .DATA_W(16), .INVERT(1), .RST_VAL(16'h0000), .TIMEOUT_CYC(100)
    ) dut16 (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx_valid(rv16), .i_rx_byte(rb16), .i_ch_en(en16),
        .o_ch_data(d16), .o_ch_update(up16), .o_frame_err(fe16), .o_err_cnt(ec16), .o_busy(bz16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic send8(input logic [7:0] b);
        rb8 = b; rv8 = 1'b1;
        @(negedge i_clk);
        rv8 = 1'b0;
    endtask

    task automatic send16(input logic [7:0] b);
        rb16 = b; rv16 = 1'b1;
        @(negedge i_clk);
        rv16 = 1'b0;
    endtask

    // Scoreboard monitor for the 8-bit instance.
    always @(negedge i_clk) begin
        if (!i_rst && (up8 != 2'b00 || fe8)) begin
            if (q8.size() == 0) begin
                check("sb8_unexpected_event", {up8, fe8}, 64'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("sb8_frame_err", fe8, e.is_err);
                check("sb8_update", up8, e.mask);
                if (e.is_err) check("sb8_err_cnt", ec8, e.ecnt);
                else          check("sb8_ch_data", d8, e.data);
            end
        end
    end

    // Scoreboard monitor for the 16-bit instance.
    always @(negedge i_clk) begin
        if (!i_rst && (up16 != 2'b00 || fe16)) begin
            if (q16.size() == 0) begin
                check("sb16_unexpected_event", {up16, fe16}, 64'd0);
            end else begin
                exp_t e;
                e = q16.pop_front();
                check("sb16_frame_err", fe16, e.is_err);
                check("sb16_update", up16, e.mask);
                if (e.is_err) check("sb16_err_cnt", ec16, e.ecnt);
                else          check("sb16_ch_data", d16, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rv8 = 1'b0; rb8 = 8'h00; en8 = 2'b11;
        rv16 = 1'b0; rb16 = 8'h00; en16 = 2'b11;
        idle(3);

        // Reset state.
        check("rst_ch_data8", d8, 16'h0000);
        check("rst_update8", up8, 2'b00);
        check("rst_frame_err8", fe8, 1'b0);
        check("rst_err_cnt8", ec8, 8'd0);
        check("rst_busy8", bz8, 1'b0);
        check("rst_ch_data16", d16, 32'h0);
        i_rst = 1'b0;
        idle(1);

        // Non-SYNC bytes in IDLE are ignored.
        send8(8'h3C); send8(8'h00);
        check("idle_junk_busy", bz8, 1'b0);

        // Commit to ch1: payload 3C inverted.
        send8(8'hA5);
        check("busy_after_sync", bz8, 1'b1);
        send8(8'h01); send8(8'h3C);
        q8.push_back('{1'b0, 2'b10, 32'h0000_C300, 8'd0});
        send8(8'h3D);
        idle(2);
        check("ch_hold_after_commit", d8, 16'hC300);

        // Bad checksum, then out-of-range address.
        send8(8'hA5); send8(8'h00); send8(8'h3C);
        q8.push_back('{1'b1, 2'b00, 32'h0, 8'd1});
        send8(8'h00);
        send8(8'hA5); send8(8'h05); send8(8'h11);
        q8.push_back('{1'b1, 2'b00, 32'h0, 8'd2});
        send8(8'h14);
        idle(2);
        check("ch_unchanged_after_errors", d8, 16'hC300);

        // 0xA5 as payload/CSUM; disabled channel drops silently.
        en8 = 2'b10;
        send8(8'hA5); send8(8'h00); send8(8'hA5); send8(8'hA5);
        idle(2);
        check("disabled_ch_no_change", d8, 16'hC300);
        check("disabled_ch_err_cnt", ec8, 8'd2);
        en8 = 2'b01;
        send8(8'hA5); send8(8'h00); send8(8'hA5);
        q8.push_back('{1'b0, 2'b01, 32'h0000_C35A, 8'd0});
        send8(8'hA5);
        idle(2);
        en8 = 2'b11;

        // Timeout after 100 idle cycles inside a frame.
        send8(8'hA5); send8(8'h01);
        idle(99);
        check("pre_timeout_err", fe8, 1'b0);
        check("pre_timeout_busy", bz8, 1'b1);
        q8.push_back('{1'b1, 2'b00, 32'h0, 8'd3});
        idle(1);
        check("post_timeout_busy", bz8, 1'b0);
        idle(2);

        // A byte in the timeout cycle wins.
        send8(8'hA5); send8(8'h01);
        idle(99);
        send8(8'h77);
        check("byte_wins_busy", bz8, 1'b1);
        q8.push_back('{1'b0, 2'b10, 32'h0000_885A, 8'd0});
        send8(8'h76);
        idle(2);

        // Reset mid-frame discards it and restores reset values.
        send8(8'hA5); send8(8'h01); send8(8'h3C);
        i_rst = 1'b1;
        idle(2);
        check("midrst_ch_data", d8, 16'h0000);
        check("midrst_err_cnt", ec8, 8'd0);
        check("midrst_busy", bz8, 1'b0);
        check("midrst_update", up8, 2'b00);
        check("midrst_frame_err", fe8, 1'b0);
        i_rst = 1'b0;
        idle(1);
        send8(8'hA5); send8(8'h00); send8(8'h0F);
        q8.push_back('{1'b0, 2'b01, 32'h0000_00F0, 8'd0});
        send8(8'h0F);
        idle(2);
        check("postrst_err_cnt", ec8, 8'd0);

        // 16-bit payload, MSB first.
        send16(8'hA5); send16(8'h01); send16(8'h12); send16(8'h34);
        q16.push_back('{1'b0, 2'b10, 32'hEDCB_0000, 8'd0});
        send16(8'h27);
        idle(2);

        // 300 bad-checksum frames saturate the error counter.
        for (int i = 1; i <= 300; i++) begin
            send16(8'hA5); send16(8'h00); send16(8'h00); send16(8'h00);
            q16.push_back('{1'b1, 2'b00, 32'h0, (i > 255) ? 8'd255 : 8'(i)});
            send16(8'h01);
        end
        idle(2);
        check("err_cnt_saturated", ec16, 8'd255);
        check("ch_data16_hold", d16, 32'hEDCB_0000);

        idle(3);
        check("sb8_drained", q8.size(), 64'd0);
        check("sb16_drained", q16.size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
